dmem_responder: RTL and testbench

- Data-memory responder serving the pipelined datapath's memory-stage load/store requests.
- Holds a word-organised RAM array and inserts a configurable number of wait states.
- Drives memstall, which the hazard unit ORs into stallF/stallD/stallE/stallM and uses to hold the M/W boundary.
- Sits beside the datapath in the top module, on the aluoutM/writedataM/readdataM interface.

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory for the M stage with WAIT_STATES stall cycles per access.
// Latency: WAIT_STATES+1 cycles per access, read data combinational in the completing cycle.
// Backpressure: memstall holds the pipeline until the access completes; optional DMEM_ALIGN_CHECK_EN flags misaligned accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] addrM,
  input  logic [3:0]  bytemaskM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        memstall,
  output logic        misalignedM
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req;
  logic [IW-1:0] idx;
  logic          complete;
  logic          mis_raw;
  logic          mis_hit;
  logic          we;
  logic          unused_addr;

  assign req = memreadM | memwriteM;
  assign idx = addrM[IW+1:2];
  // Upper address bits alias and byte offset is only meaningful to the alignment check.
  assign unused_addr = ^{addrM[31:IW+2], addrM[1:0]};

  // State and wait counter; reset aborts any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: start counting on a new request, count down, or abort when req drops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req && (WAIT_STATES != 0)) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Alignment classification of the current request (only active when the check is built in).
  always_comb begin
    mis_raw = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    if ((addrM[1:0] != 2'b00) && (bytemaskM == 4'b1111)) mis_raw = 1'b1;
    if (addrM[0] && ((bytemaskM == 4'b0011) || (bytemaskM == 4'b1100))) mis_raw = 1'b1;
    if (memreadM && (addrM[1:0] != 2'b00)) mis_raw = 1'b1;
`endif
  end

  // Outputs: stall until the completing cycle; everything forced quiet while reset is low.
  always_comb begin
    complete = 1'b0;
    memstall = 1'b0;
    if (reset && req) begin
      case (state_q)
        IDLE: begin
          if (WAIT_STATES == 0) complete = 1'b1;
          else                  memstall = 1'b1;
        end
        WAIT: begin
          if (cnt_q != 4'd0) memstall = 1'b1;
          else               complete = 1'b1;
        end
        default: begin
          complete = 1'b0;
          memstall = 1'b0;
        end
      endcase
    end
    mis_hit     = complete & mis_raw;
    misalignedM = mis_hit;
    we          = complete & memwriteM & ~mis_hit;
    readdataM   = (complete && memreadM && !mis_hit) ? mem_q[idx] : 32'd0;
  end

  // Byte-masked store at the edge ending the completing cycle; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (bytemaskM[i]) mem_q[idx][8*i +: 8] <= writedataM[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  mask = 4'd0;
  logic [31:0] wdata = 32'd0;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        stall_a, stall_b, stall_c;
  logic        mis_a, mis_b, mis_c;

  logic [31:0] mon_rdata;
  logic        mon_stall;
  logic        mon_mis;
  int          sel = 0;
  logic        mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          stalls;
  } exp_t;
  exp_t exp_q[$];
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(rst_n), .memreadM(rd), .memwriteM(wr), .addrM(addr),
    .bytemaskM(mask), .writedataM(wdata), .readdataM(rdata_a), .memstall(stall_a),
    .misalignedM(mis_a));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(rst_n), .memreadM(rd), .memwriteM(wr), .addrM(addr),
    .bytemaskM(mask), .writedataM(wdata), .readdataM(rdata_b), .memstall(stall_b),
    .misalignedM(mis_b));
  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) dut_c (
    .clk(clk), .reset(rst_n), .memreadM(rd), .memwriteM(wr), .addrM(addr),
    .bytemaskM(mask), .writedataM(wdata), .readdataM(rdata_c), .memstall(stall_c),
    .misalignedM(mis_c));

  always_comb begin
    case (sel)
      1:       begin mon_rdata = rdata_b; mon_stall = stall_b; mon_mis = mis_b; end
      2:       begin mon_rdata = rdata_c; mon_stall = stall_c; mon_mis = mis_c; end
      default: begin mon_rdata = rdata_a; mon_stall = stall_a; mon_mis = mis_a; end
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: counts stall cycles, compares each completing cycle against the scoreboard.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (rd || wr) begin
        if (mon_stall) begin
          stall_cnt++;
          chk("rdata_during_stall", mon_rdata, 32'd0);
        end else if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
          stall_cnt = 0;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rdata", mon_rdata, e.rdata);
          chk("misaligned", {31'd0, mon_mis}, {31'd0, e.mis});
          chk("stall_cycles", stall_cnt, e.stalls);
          stall_cnt = 0;
        end
      end else begin
        chk("idle_stall", {31'd0, mon_stall}, 32'd0);
        chk("idle_rdata", mon_rdata, 32'd0);
        stall_cnt = 0;
      end
    end
  end

  function automatic int ws_of(input int s);
    return (s == 1) ? 0 : (s == 2) ? 3 : 2;
  endfunction

  // Issue one access, push its expectation, hold until the completing cycle passes.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input logic [31:0] exp_rd, input logic exp_mis);
    exp_t e;
    bit   done = 0;
    e.rdata = exp_rd; e.mis = exp_mis; e.stalls = ws_of(sel);
    exp_q.push_back(e);
    rd = r; wr = w; addr = a; mask = m; wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mon_stall) begin done = 1; break; end
    end
    if (!done) chk("access_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    rd = 1'b0; wr = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rd = 1'b1; addr = 32'h10;
    #1;
    chk("reset_stall_a", {31'd0, stall_a}, 32'd0);
    chk("reset_stall_c", {31'd0, stall_c}, 32'd0);
    chk("reset_rdata_a", rdata_a, 32'd0);
    chk("reset_mis_a", {31'd0, mis_a}, 32'd0);
    rd = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // WAIT_STATES=2 instance
    sel = 0;
    dut_a.mem_q[8] = 32'h11223344;
    dut_a.mem_q[5] = 32'h0BADCAFE;
    mon_en = 1'b1;
    access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);
    idle(2);
    access(1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'h20, 4'h0, 32'd0, 32'h11BB33DD, 1'b0);
    idle(1);
    access(1'b0, 1'b1, 32'h400, 4'hF, 32'h5, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'h0, 4'h0, 32'd0, 32'h00000005, 1'b0);
    access(1'b1, 1'b1, 32'h10, 4'hF, 32'h12345678, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b0, 32'h10, 4'h0, 32'd0, 32'h12345678, 1'b0);
    access(1'b0, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'h10, 4'h0, 32'd0, 32'h12345678, 1'b0);
    idle(1);
    // Abort: store dropped after one stalled cycle must not write
    rd = 1'b0; wr = 1'b1; addr = 32'h14; mask = 4'hF; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    idle(2);
    access(1'b1, 1'b0, 32'h14, 4'h0, 32'd0, 32'h0BADCAFE, 1'b0);
`ifdef DMEM_ALIGN_CHECK_EN
    access(1'b0, 1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b1);
    access(1'b1, 1'b0, 32'h20, 4'h0, 32'd0, 32'h11BB33DD, 1'b0);
    access(1'b1, 1'b0, 32'h23, 4'h0, 32'd0, 32'd0, 1'b1);
    access(1'b0, 1'b1, 32'h21, 4'b0011, 32'h0000EEEE, 32'd0, 1'b1);
`else
    access(1'b0, 1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'h23, 4'h0, 32'd0, 32'hFFFFFFFF, 1'b0);
`endif
    idle(2);

    // WAIT_STATES=0 instance: back-to-back single-cycle reads
    sel = 1;
    dut_b.mem_q[0] = 32'hA0A0A0A0;
    dut_b.mem_q[1] = 32'hA1A1A1A1;
    dut_b.mem_q[2] = 32'hA2A2A2A2;
    access(1'b1, 1'b0, 32'h0, 4'h0, 32'd0, 32'hA0A0A0A0, 1'b0);
    access(1'b1, 1'b0, 32'h4, 4'h0, 32'd0, 32'hA1A1A1A1, 1'b0);
    access(1'b1, 1'b0, 32'h8, 4'h0, 32'd0, 32'hA2A2A2A2, 1'b0);
    access(1'b0, 1'b1, 32'h4, 4'b1000, 32'h55000000, 32'd0, 1'b0);
    access(1'b1, 1'b0, 32'h4, 4'h0, 32'd0, 32'h55A1A1A1, 1'b0);
    idle(2);

    // WAIT_STATES=3 instance: reset mid-access drops the store
    mon_en = 1'b0;
    sel = 2;
    dut_c.mem_q[2] = 32'h00000077;
    rd = 1'b0; wr = 1'b1; addr = 32'h8; mask = 4'hF; wdata = 32'h1;
    #1;
    chk("c_stall_first", {31'd0, mon_stall}, 32'd1);
    @(posedge clk); #1;
    chk("c_stall_second", {31'd0, mon_stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("c_reset_stall", {31'd0, mon_stall}, 32'd0);
    chk("c_reset_rdata", mon_rdata, 32'd0);
    chk("c_reset_mis", {31'd0, mon_mis}, 32'd0);
    wr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    access(1'b1, 1'b0, 32'h8, 4'h0, 32'd0, 32'h00000077, 1'b0);
    idle(3);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
